// File: rtl/sar_result_reader.sv
// sar_result_reader: conversion controller and MSB-first bit-serial result
// reader for a SAR ADC. A single holding register sits in front of the
// shifter so a conversion can finish while the previous word is still
// being streamed out.
module sar_result_reader #(
    parameter int N_BITS   = 12,
    parameter int CONV_GAP = 2
) (
    input  logic              clk_sar,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              eoc,
    input  logic [N_BITS-1:0] data_in,
    output logic              sar_reset,
    output logic              ser_data,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_frame,
    output logic              overrun,
    output logic [7:0]        conv_count
);

    localparam int CNT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int GAP_W = (CONV_GAP > 1) ? $clog2(CONV_GAP) : 1;

    typedef enum logic [1:0] {IDLE, CONVERT, GAP} conv_state_t;
    typedef enum logic {S_IDLE, S_SHIFT} ser_state_t;

    conv_state_t       conv_state_q, conv_state_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic              sar_reset_q, sar_reset_d;
    logic              eoc_prev_q, eoc_prev_d;

    ser_state_t        ser_state_q, ser_state_d;
    logic [N_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              ser_valid_q, ser_valid_d;
    logic              ser_frame_q, ser_frame_d;

    logic [N_BITS-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        conv_count_q, conv_count_d;

    logic              eoc_rise;
    logic              capture;
    logic              accept;
    logic              last_accept;
    logic              to_shifter;
    logic              to_hold;
    logic              drop;
    logic              load_en;
    logic [N_BITS-1:0] load_word;

    // Conversion sequencing: start on enable, capture on the eoc rising edge, then hold the SAR in reset for the gap.
    always_comb begin
        conv_state_d = conv_state_q;
        gap_cnt_d    = gap_cnt_q;
        capture      = 1'b0;
        eoc_prev_d   = eoc;
        eoc_rise     = (conv_state_q == CONVERT) && eoc && !eoc_prev_q;
        case (conv_state_q)
            IDLE: begin
                if (enable) begin
                    conv_state_d = CONVERT;
                end
            end
            CONVERT: begin
                if (!enable) begin
                    conv_state_d = IDLE;
                end else if (eoc_rise) begin
                    capture      = 1'b1;
                    conv_state_d = GAP;
                    gap_cnt_d    = GAP_W'(CONV_GAP - 1);
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    conv_state_d = enable ? CONVERT : IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: begin
                conv_state_d = IDLE;
            end
        endcase
        sar_reset_d = (conv_state_d != CONVERT);
    end

    // Route a captured word: straight into a free shifter, else the holding register, else drop it.
    always_comb begin
        accept      = ser_valid_q && ser_ready;
        last_accept = accept && (bit_cnt_q == '0);
        to_shifter  = capture && ((ser_state_q == S_IDLE) || (last_accept && !hold_full_q));
        to_hold     = capture && !to_shifter && (!hold_full_q || last_accept);
        drop        = capture && !to_shifter && !to_hold;
    end

    // Serializer: shift out MSB-first on each handshake, refilling from the holding register without a bubble.
    always_comb begin
        ser_state_d  = ser_state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        ser_valid_d  = ser_valid_q;
        ser_frame_d  = ser_frame_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        load_en      = 1'b0;
        load_word    = data_in;
        if (ser_state_q == S_IDLE) begin
            if (to_shifter) begin
                load_en = 1'b1;
            end
        end else if (last_accept) begin
            if (hold_full_q) begin
                load_en     = 1'b1;
                load_word   = hold_q;
                hold_full_d = 1'b0;
            end else if (to_shifter) begin
                load_en = 1'b1;
            end else begin
                ser_state_d = S_IDLE;
                ser_valid_d = 1'b0;
                ser_frame_d = 1'b0;
                shift_d     = '0;
            end
        end else if (accept) begin
            shift_d     = shift_q << 1;
            bit_cnt_d   = bit_cnt_q - 1'b1;
            ser_frame_d = 1'b0;
        end
        if (load_en) begin
            ser_state_d = S_SHIFT;
            shift_d     = load_word;
            bit_cnt_d   = CNT_W'(N_BITS - 1);
            ser_valid_d = 1'b1;
            ser_frame_d = 1'b1;
        end
        if (to_hold) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end
        conv_count_d = conv_count_q + {7'd0, capture};
        overrun_d    = overrun_q | drop;
    end

    // State registers for both the conversion FSM and the serializer.
    always_ff @(posedge clk_sar or negedge rst_n) begin
        if (!rst_n) begin
            conv_state_q <= IDLE;
            gap_cnt_q    <= '0;
            sar_reset_q  <= 1'b1;
            eoc_prev_q   <= 1'b0;
            ser_state_q  <= S_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            ser_valid_q  <= 1'b0;
            ser_frame_q  <= 1'b0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            overrun_q    <= 1'b0;
            conv_count_q <= '0;
        end else begin
            conv_state_q <= conv_state_d;
            gap_cnt_q    <= gap_cnt_d;
            sar_reset_q  <= sar_reset_d;
            eoc_prev_q   <= eoc_prev_d;
            ser_state_q  <= ser_state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            ser_valid_q  <= ser_valid_d;
            ser_frame_q  <= ser_frame_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            overrun_q    <= overrun_d;
            conv_count_q <= conv_count_d;
        end
    end

    assign sar_reset  = sar_reset_q;
    assign ser_data   = shift_q[N_BITS-1];
    assign ser_valid  = ser_valid_q;
    assign ser_frame  = ser_frame_q;
    assign overrun    = overrun_q;
    assign conv_count = conv_count_q;

endmodule

// File: tb/tb_sar_result_reader.sv
// Directed testbench for sar_result_reader: the bench plays the SAR logic
// and the downstream readout, with hand-computed expected values.
module tb_sar_result_reader;

    logic        clk_sar;
    logic        rst_n;
    logic        enable;
    logic        eoc;
    logic [11:0] data_in;
    logic        sar_reset;
    logic        ser_data;
    logic        ser_valid;
    logic        ser_ready;
    logic        ser_frame;
    logic        overrun;
    logic [7:0]  conv_count;

    int checks;
    int failures;

    sar_result_reader #(
        .N_BITS   (12),
        .CONV_GAP (2)
    ) dut (
        .clk_sar    (clk_sar),
        .rst_n      (rst_n),
        .enable     (enable),
        .eoc        (eoc),
        .data_in    (data_in),
        .sar_reset  (sar_reset),
        .ser_data   (ser_data),
        .ser_valid  (ser_valid),
        .ser_ready  (ser_ready),
        .ser_frame  (ser_frame),
        .overrun    (overrun),
        .conv_count (conv_count)
    );

    // Free-running SAR clock.
    initial begin
        clk_sar = 1'b0;
        forever #5 clk_sar = ~clk_sar;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk_sar);
        @(negedge clk_sar);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic e, input logic [11:0] d, input logic rdy);
        enable    = en;
        eoc       = e;
        data_in   = d;
        ser_ready = rdy;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Wait for the SAR to be released, let it "convert" two cycles, then raise eoc with the result.
    task automatic runConversion(input logic [11:0] word, input logic keep_eoc);
        for (int n = 0; n < 20; n++) begin
            if (sar_reset === 1'b0) break;
            tick();
        end
        checkOutput("conv_start", sar_reset, 0);
        tick();
        tick();
        data_in = word;
        eoc     = 1'b1;
        tick();
        if (!keep_eoc) eoc = 1'b0;
    endtask

    // Expect one full word on consecutive accepted cycles (ser_ready must be high).
    task automatic checkWord(input logic [11:0] word);
        logic [11:0] w;
        w = word;
        for (int i = 0; i < 12; i++) begin
            checkOutput("word_valid", ser_valid, 1);
            checkOutput("word_bit", ser_data, w[11-i]);
            checkOutput("word_frame", ser_frame, (i == 0) ? 1 : 0);
            tick();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b0);

        // Reset values
        tick();
        tick();
        checkOutput("rst_sar_reset", sar_reset, 1);
        checkOutput("rst_ser_valid", ser_valid, 0);
        checkOutput("rst_ser_data", ser_data, 0);
        checkOutput("rst_ser_frame", ser_frame, 0);
        checkOutput("rst_overrun", overrun, 0);
        checkOutput("rst_conv_count", conv_count, 0);
        rst_n = 1'b1;
        tick();
        checkOutput("idle_sar_reset", sar_reset, 1);

        // Basic conversion of 0xA5C with ready held high
        $display("[TB] basic conversion 0xA5C");
        applyStimulus(1'b1, 1'b0, 12'h000, 1'b1);
        tick();
        checkOutput("start_sar_reset", sar_reset, 0);
        tick();
        tick();
        applyStimulus(1'b1, 1'b1, 12'hA5C, 1'b1);
        tick();
        checkOutput("cap_sar_reset", sar_reset, 1);
        checkOutput("cap_conv_count", conv_count, 1);
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b1);
        checkWord(12'hA5C);
        checkOutput("basic_end_valid", ser_valid, 0);
        checkOutput("basic_end_sar_reset", sar_reset, 1);

        // Stalling downstream: ready toggles every cycle, word 0x801
        $display("[TB] stalled transfer 0x801");
        applyStimulus(1'b1, 1'b0, 12'h000, 1'b0);
        runConversion(12'h801, 1'b0);
        enable = 1'b0;
        checkOutput("stall_conv_count", conv_count, 2);
        begin
            logic [11:0] w;
            w = 12'h801;
            for (int j = 0; j < 12; j++) begin
                ser_ready = 1'b0;
                checkOutput("stall_valid", ser_valid, 1);
                checkOutput("stall_bit", ser_data, w[11-j]);
                tick();
                checkOutput("stall_hold_valid", ser_valid, 1);
                checkOutput("stall_hold_bit", ser_data, w[11-j]);
                ser_ready = 1'b1;
                tick();
            end
        end
        checkOutput("stall_end_valid", ser_valid, 0);

        // Overrun: ready low, three conversions
        $display("[TB] overrun with three conversions");
        applyReset();
        applyStimulus(1'b1, 1'b0, 12'h000, 1'b0);
        runConversion(12'h111, 1'b0);
        runConversion(12'h222, 1'b0);
        checkOutput("ovr_not_yet", overrun, 0);
        runConversion(12'h333, 1'b0);
        enable = 1'b0;
        checkOutput("ovr_flag", overrun, 1);
        checkOutput("ovr_conv_count", conv_count, 3);
        checkOutput("ovr_valid", ser_valid, 1);
        checkOutput("ovr_msb", ser_data, 0);
        ser_ready = 1'b1;
        checkWord(12'h111);
        checkWord(12'h222);
        checkOutput("ovr_end_valid", ser_valid, 0);
        checkOutput("ovr_sticky", overrun, 1);

        // Holding register refilled on the same edge it drains
        $display("[TB] same-edge refill");
        applyReset();
        applyStimulus(1'b1, 1'b0, 12'h000, 1'b0);
        runConversion(12'h123, 1'b0);
        runConversion(12'h456, 1'b0);
        for (int n = 0; n < 20; n++) begin
            if (sar_reset === 1'b0) break;
            tick();
        end
        checkOutput("refill_conv_start", sar_reset, 0);
        ser_ready = 1'b1;
        for (int n = 0; n < 11; n++) tick();
        applyStimulus(1'b1, 1'b1, 12'h789, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b1);
        checkOutput("refill_overrun", overrun, 0);
        checkOutput("refill_conv_count", conv_count, 3);
        checkWord(12'h456);
        checkWord(12'h789);
        checkOutput("refill_end_valid", ser_valid, 0);

        // Abort on enable drop; a later eoc pulse is ignored
        $display("[TB] abort conversion");
        applyStimulus(1'b1, 1'b0, 12'h000, 1'b1);
        tick();
        checkOutput("abort_start", sar_reset, 0);
        tick();
        enable = 1'b0;
        tick();
        checkOutput("abort_sar_reset", sar_reset, 1);
        applyStimulus(1'b0, 1'b1, 12'hFFF, 1'b1);
        tick();
        checkOutput("abort_valid", ser_valid, 0);
        eoc = 1'b0;
        tick();
        checkOutput("abort_conv_count", conv_count, 3);

        // eoc held high across the gap must not re-trigger
        $display("[TB] eoc held high across gap");
        applyStimulus(1'b1, 1'b0, 12'h000, 1'b1);
        runConversion(12'h0F0, 1'b1);
        checkWord(12'h0F0);
        checkOutput("held_conv_count", conv_count, 4);
        checkOutput("held_sar_reset", sar_reset, 0);
        checkOutput("held_valid", ser_valid, 0);
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b1);
        tick();

        // Asynchronous reset mid-word, then a clean frame
        $display("[TB] reset mid-word");
        applyStimulus(1'b1, 1'b0, 12'h000, 1'b1);
        runConversion(12'hABC, 1'b0);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", ser_valid, 0);
        checkOutput("mid_rst_data", ser_data, 0);
        checkOutput("mid_rst_frame", ser_frame, 0);
        checkOutput("mid_rst_sar_reset", sar_reset, 1);
        checkOutput("mid_rst_conv_count", conv_count, 0);
        tick();
        rst_n = 1'b1;
        runConversion(12'h5A5, 1'b0);
        enable = 1'b0;
        checkWord(12'h5A5);
        checkOutput("post_rst_conv_count", conv_count, 1);
        checkOutput("post_rst_overrun", overrun, 0);
        checkOutput("post_rst_end_valid", ser_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
